count_monitor: RTL and testbench

Receive-side checker for an 8-bit free-running counter bus such as a `count[7:0]` output. It samples the bus on qualified cycles and locks onto a +1 (mod 2^W) sequence. Once locked it flags every break in the sequence, keeps a saturating error tally, and optionally detects a bus frozen at a constant value, such as a counter synthesised to a tied-off net. It sits beside the counter under test in the example designs and in board-level self-check wrappers.

---
 rtl/count_mon_pkg.sv | 24 ++
 rtl/count_monitor_if.sv | 34 +++
 rtl/count_mon_stuck_det.sv | 55 +++++
 rtl/count_monitor.sv | 144 ++++++++++++++
 tb/tb_count_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_mon_pkg
// Purpose  : Shared types and default parameter values for the count_monitor
//            block (free-running counter bus checker).
// Contents : count_mon_state_e - tracking FSM state encoding
//            C_DEF_*           - default parameter values
// Revision : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

  typedef enum logic [1:0] {
    ACQ0   = 2'd0,  // no base sample yet
    ACQ    = 2'd1,  // counting consecutive increments toward lock
    LOCKED = 2'd2   // sequence established, every sample must be +1
  } count_mon_state_e;

  localparam int C_DEF_WIDTH       = 8;
  localparam int C_DEF_LOCK_LEN    = 4;
  localparam int C_DEF_STUCK_LIMIT = 16;
  localparam int C_DEF_ERR_W       = 16;

endpackage
`default_nettype wire

// File: rtl/count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor_if
// Purpose  : Bundles the monitored count bus, its qualifiers and the
//            checker status outputs.
// Modports : master - drives count/sample_en/clr_err, observes status
//            slave  - the checker: consumes count/sample_en/clr_err,
//                     drives locked/mismatch/stuck/err_cnt/last_count
// Revision : 1.0 - initial release
// ============================================================================
interface count_monitor_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 16
);
  logic [WIDTH-1:0] count;
  logic             sample_en;
  logic             clr_err;
  logic             locked;
  logic             mismatch;
  logic             stuck;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] last_count;

  modport master (
    output count, sample_en, clr_err,
    input  locked, mismatch, stuck, err_cnt, last_count
  );

  modport slave (
    input  count, sample_en, clr_err,
    output locked, mismatch, stuck, err_cnt, last_count
  );
endinterface
`default_nettype wire

// File: rtl/count_mon_stuck_det.sv
`default_nettype none
// ============================================================================
// Module   : count_mon_stuck_det
// Purpose  : Run-length detector for a frozen bus. Counts identical
//            consecutive samples (saturating at STUCK_LIMIT) and raises a
//            sticky stuck flag when the run reaches STUCK_LIMIT.
// Ports    : clk, rstn (async active-low)
//            sample_en - a sample is taken this cycle
//            same      - current sample equals the previous sample
//            clr       - synchronous clear of the sticky flag
//            stuck     - registered sticky frozen-bus flag
// Revision : 1.0 - initial release
// ============================================================================
module count_mon_stuck_det #(
  parameter int STUCK_LIMIT = 16
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic sample_en,
  input  wire logic same,
  input  wire logic clr,
  output logic      stuck
);

  localparam int C_RUN_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [C_RUN_W-1:0] C_LIMIT = C_RUN_W'(STUCK_LIMIT);

  logic [C_RUN_W-1:0] run_q, run_d;
  logic               stuck_q, stuck_d;

  always_comb begin
    run_d   = run_q;
    stuck_d = clr ? 1'b0 : stuck_q;
    if (sample_en) begin
      // A differing sample starts a new run of length one.
      if (!same)                run_d = C_RUN_W'(1);
      else if (run_q != C_LIMIT) run_d = run_q + C_RUN_W'(1);
      if (run_d == C_LIMIT) stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor
// Purpose  : Receive-side checker for a free-running counter bus. Locks onto
//            a +1 (mod 2^WIDTH) sequence, flags every break once locked,
//            keeps a saturating error tally and (optionally) detects a
//            frozen bus.
// Ports    : clk  - single clock, posedge
//            rstn - asynchronous active-low reset
//            bus  - count_monitor_if.slave (count, sample_en, clr_err in;
//                   locked, mismatch, stuck, err_cnt, last_count out)
// Config   : COUNT_MON_STUCK_DET_EN - when defined, builds the frozen-bus
//            detector; otherwise stuck is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH       = C_DEF_WIDTH,
  parameter int LOCK_LEN    = C_DEF_LOCK_LEN,
  parameter int STUCK_LIMIT = C_DEF_STUCK_LIMIT,
  parameter int ERR_W       = C_DEF_ERR_W
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  count_monitor_if.slave bus
);

  if (LOCK_LEN < 1 || STUCK_LIMIT < 2) begin : g_param_check
    $error("count_monitor: LOCK_LEN must be >= 1 and STUCK_LIMIT >= 2");
  end

  localparam int C_RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [C_RUN_W-1:0] C_LAST_RUN = C_RUN_W'(LOCK_LEN - 1);

  count_mon_state_e   state_q, state_d;
  logic [WIDTH-1:0]   last_count_q, last_count_d;
  logic [C_RUN_W-1:0] run_q, run_d;
  logic               locked_q, locked_d;
  logic               mismatch_q, mismatch_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               w_inc_ok;
  logic               w_lock_evt;
  logic               w_break_evt;
  logic [ERR_W-1:0]   w_err_base;
  logic               w_stuck;

  // Modular +1 compare: WIDTH-bit sum makes 2^WIDTH-1 -> 0 a valid step.
  assign w_inc_ok    = (bus.count == last_count_q + WIDTH'(1));
  assign w_lock_evt  = bus.sample_en && (state_q == ACQ) && w_inc_ok &&
                       (run_q == C_LAST_RUN);
  assign w_break_evt = bus.sample_en && (state_q == LOCKED) && !w_inc_ok;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ACQ0;
      last_count_q <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_count_q <= last_count_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state logic; every sample becomes the new reference value.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    last_count_d = last_count_q;
    if (bus.sample_en) begin
      last_count_d = bus.count;
      case (state_q)
        ACQ0: begin
          run_d   = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (w_inc_ok) begin
            run_d = run_q + C_RUN_W'(1);
            if (run_q == C_LAST_RUN) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!w_inc_ok) begin
            run_d   = '0;
            state_d = ACQ;
          end
        end
        default: state_d = ACQ0;
      endcase
    end
  end

  // Registered-output logic. A clear is applied before a same-cycle error
  // is counted, so clear+mismatch leaves the tally at one.
  always_comb begin
    locked_d   = locked_q;
    mismatch_d = w_break_evt;
    if (w_lock_evt)  locked_d = 1'b1;
    if (w_break_evt) locked_d = 1'b0;

    w_err_base = bus.clr_err ? '0 : err_cnt_q;
    err_cnt_d  = w_err_base;
    if (w_break_evt && (w_err_base != {ERR_W{1'b1}}))
      err_cnt_d = w_err_base + ERR_W'(1);
  end

`ifdef COUNT_MON_STUCK_DET_EN
  logic w_same;
  assign w_same = (bus.count == last_count_q);

  count_mon_stuck_det #(
    .STUCK_LIMIT (STUCK_LIMIT)
  ) u_stuck_det (
    .clk       (clk),
    .rstn      (rstn),
    .sample_en (bus.sample_en),
    .same      (w_same),
    .clr       (bus.clr_err),
    .stuck     (w_stuck)
  );
`else
  assign w_stuck = 1'b0;
`endif

  assign bus.locked     = locked_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.stuck      = w_stuck;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.last_count = last_count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_monitor
// Purpose  : Self-checking bench for count_monitor. Two instances share the
//            stimulus: the default one (ERR_W=16) and a narrow-tally one
//            (ERR_W=2) to exercise saturation. A sample-level model predicts
//            every output each cycle; literal checks pin key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0] t_count;
  logic       t_se;
  logic       t_clr;

  count_monitor_if #(.WIDTH(8), .ERR_W(16)) if_a ();
  count_monitor_if #(.WIDTH(8), .ERR_W(2))  if_b ();

  assign if_a.count     = t_count;
  assign if_a.sample_en = t_se;
  assign if_a.clr_err   = t_clr;
  assign if_b.count     = t_count;
  assign if_b.sample_en = t_se;
  assign if_b.clr_err   = t_clr;

  count_monitor #(.WIDTH(8), .LOCK_LEN(4), .STUCK_LIMIT(16), .ERR_W(16)) dut (
    .clk (clk), .rstn (rstn), .bus (if_a)
  );
  count_monitor #(.WIDTH(8), .LOCK_LEN(4), .STUCK_LIMIT(16), .ERR_W(2)) dut_sat (
    .clk (clk), .rstn (rstn), .bus (if_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sample-level model ----------------
  typedef struct {
    int last;     // most recent sample
    int inc;      // consecutive +1 steps since the base sample
    int err;      // tally, saturating at 65535
    int err2;     // tally, saturating at 3
    int srun;     // identical-sample run length
    bit base;     // a base sample has been seen since reset
    bit locked;
    bit mis;
    bit stuck;
  } model_t;

  model_t m;

  function automatic model_t step(model_t cur, bit se, int cnt, bit clr);
    model_t n;
    bit     inc_ok;
    n      = cur;
    n.mis  = 1'b0;
    inc_ok = (cnt == ((cur.last + 1) % 256));
    if (clr) begin
      n.err   = 0;
      n.err2  = 0;
      n.stuck = 1'b0;
    end
    if (se) begin
      n.srun = (cnt == cur.last) ? ((cur.srun < 16) ? cur.srun + 1 : 16) : 1;
`ifdef COUNT_MON_STUCK_DET_EN
      if (n.srun >= 16) n.stuck = 1'b1;
`endif
      if (!cur.base) begin
        n.base = 1'b1;
        n.inc  = 0;
      end else if (cur.locked) begin
        if (!inc_ok) begin
          n.mis    = 1'b1;
          n.err    = (n.err < 65535) ? n.err + 1 : n.err;
          n.err2   = (n.err2 < 3) ? n.err2 + 1 : n.err2;
          n.locked = 1'b0;
          n.inc    = 0;
        end
      end else if (inc_ok) begin
        n.inc = cur.inc + 1;
        if (n.inc >= 4) n.locked = 1'b1;
      end else begin
        n.inc = 0;
      end
      n.last = cnt;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '{default: 0};
    else       m <= step(m, t_se, int'(t_count), t_clr);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("locked",     if_a.locked,     m.locked);
    chk("mismatch",   if_a.mismatch,   m.mis);
    chk("stuck",      if_a.stuck,      m.stuck);
    chk("err_cnt",    if_a.err_cnt,    m.err);
    chk("last_count", if_a.last_count, m.last);
    chk("err_cnt_w2", if_b.err_cnt,    m.err2);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit se, input int c, input bit clr);
    t_se    = se;
    t_count = c[7:0];
    t_clr   = clr;
    @(posedge clk);
    @(negedge clk);
    t_se  = 1'b0;
    t_clr = 1'b0;
  endtask

  // First sample breaks the lock (and becomes the base), four more relock.
  task automatic break_and_relock(input int b);
    for (int k = 0; k <= 4; k++) cyc(1'b1, b + k, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    t_count = '0;
    t_se    = 1'b0;
    t_clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_locked",   if_a.locked,     0);
    chk("rst_mismatch", if_a.mismatch,   0);
    chk("rst_stuck",    if_a.stuck,      0);
    chk("rst_err",      if_a.err_cnt,    0);
    chk("rst_last",     if_a.last_count, 0);
    rstn = 1'b1;

    // Lock on 0..4
    for (int i = 0; i <= 4; i++) begin
      cyc(1'b1, i, 1'b0);
      if (i == 3) chk("lit_not_locked_yet", if_a.locked, 0);
    end
    chk("lit_locked_after_4", if_a.locked, 1);
    chk("lit_err_after_lock", if_a.err_cnt, 0);

    // Run through the wrap 0xFE,0xFF,0x00,0x01 and on to 0x10
    for (int i = 5; i <= 'h110; i++) begin
      cyc(1'b1, i & 'hFF, 1'b0);
      if (i == 'h101) chk("lit_locked_over_wrap", if_a.locked, 1);
    end

    // Break at 0x10 -> 0x20
    cyc(1'b1, 'h20, 1'b0);
    chk("lit_mismatch_pulse", if_a.mismatch, 1);
    chk("lit_err_one",        if_a.err_cnt, 1);
    chk("lit_unlocked",       if_a.locked, 0);
    cyc(1'b0, 'h00, 1'b0);
    chk("lit_mismatch_ends",  if_a.mismatch, 0);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 'h20 + k, 1'b0);
    chk("lit_relocked", if_a.locked, 1);

    // Idle cycles: everything holds regardless of count
    for (int k = 0; k < 3; k++) cyc(1'b0, 'h99, 1'b0);

    // Four more breaks: tally 5, narrow tally saturates at 3
    break_and_relock('h60);
    break_and_relock('hA0);
    break_and_relock('hE0);
    break_and_relock('h30);
    chk("lit_err_five", if_a.err_cnt, 5);
    chk("lit_err_sat3", if_b.err_cnt, 3);

    // Clear together with a mismatch -> 1
    cyc(1'b1, 'h00, 1'b1);
    chk("lit_clr_plus_mis", if_a.err_cnt, 1);
    chk("lit_clr_plus_mis_w2", if_b.err_cnt, 1);
    for (int k = 1; k <= 4; k++) cyc(1'b1, k, 1'b0);

    // Clear alone leaves lock intact
    cyc(1'b0, 'h00, 1'b1);
    chk("lit_clr_alone_err", if_a.err_cnt, 0);
    chk("lit_clr_alone_lock", if_a.locked, 1);

    break_and_relock('h50);
    break_and_relock('h90);
    chk("lit_err_two", if_a.err_cnt, 2);

    // Asynchronous reset mid-lock
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("lit_arst_locked", if_a.locked, 0);
    chk("lit_arst_err",    if_a.err_cnt, 0);
    chk("lit_arst_last",   if_a.last_count, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 'h77, 1'b0);
    chk("lit_rebase_no_mis", if_a.mismatch, 0);
    chk("lit_rebase_last",   if_a.last_count, 'h77);

    // Frozen bus: 16 identical samples
    pulse_reset();
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 'h00, 1'b0);
      if (k == 15) chk("lit_stuck_not_yet", if_a.stuck, 0);
    end
`ifdef COUNT_MON_STUCK_DET_EN
    chk("lit_stuck_set", if_a.stuck, 1);
`else
    chk("lit_stuck_tied", if_a.stuck, 0);
`endif
    cyc(1'b0, 'h00, 1'b1);
    chk("lit_stuck_clr", if_a.stuck, 0);
    chk("lit_stuck_clr_err", if_a.err_cnt, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
